// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU sequencer: FSM state codes and op counter limit.
// Combinational definitions only; no latency, no backpressure.
package alu_seq_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    EXEC    = 2'd2,
    SHOW    = 2'd3
  } state_t;

  localparam logic [7:0] OP_COUNT_MAX = 8'd255;

endpackage

// File: rtl/key_conditioner.sv
// Turns the raw active-low push-button into a one-cycle step pulse on each press.
// Latency 3 cycles (sync + edge), plus DEBOUNCE_CYCLES when ALU_SEQ_DEBOUNCE_EN is defined.
// No backpressure: a held key gives exactly one pulse, release re-arms it.
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic step
);

  logic sync1, sync2;
  logic level, level_d;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LOW_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] low_cnt;
  logic          stable;

  // Any synchronised high sample restarts the stable-low window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_cnt <= '0;
      stable  <= 1'b1;
    end else if (sync2) begin
      low_cnt <= '0;
      stable  <= 1'b1;
    end else if (low_cnt == LOW_LAST) begin
      stable  <= 1'b0;
    end else begin
      low_cnt <= low_cnt + CW'(1);
    end
  end

  assign level = stable;
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d <= 1'b1;
      step    <= 1'b0;
    end else begin
      level_d <= level;
      step    <= level_d & ~level;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences operand A, operand B and op entry into the external add/sub ALU, then latches the result.
// Result captured SETTLE cycles after entering EXEC; steps arrive via key_conditioner (ALU_SEQ_DEBOUNCE_EN adds debounce).
// No backpressure: steps arriving in EXEC are dropped, clr wins over step.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int SETTLE          = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_n,
  input  logic               clr,
  input  logic               chain,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               op_sel,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_s,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_cout,
  output logic [WIDTH-1:0]   result_q,
  output logic               cout_q,
  output logic [STATE_W-1:0] state_q,
  output logic               valid,
  output logic [7:0]         op_count
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  state_t           state;
  logic [CNT_W-1:0] settle_cnt;
  logic             step;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .step  (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ENTER_A;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      valid      <= 1'b0;
      op_count   <= 8'd0;
    end else if (clr) begin
      state      <= ENTER_A;
      settle_cnt <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_s      <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      valid      <= 1'b0;
      op_count   <= 8'd0;
    end else begin
      case (state)
        ENTER_A: if (step) begin
          alu_a <= data_in;
          state <= ENTER_B;
        end
        ENTER_B: if (step) begin
          alu_b      <= data_in;
          alu_s      <= op_sel;
          settle_cnt <= '0;
          state      <= EXEC;
        end
        // Operands stay frozen here so the ALU output is settled at capture.
        EXEC: if (settle_cnt == SETTLE_LAST) begin
          result_q <= alu_result;
          cout_q   <= alu_cout;
          if (op_count != OP_COUNT_MAX) op_count <= op_count + 8'd1;
          valid    <= 1'b1;
          state    <= SHOW;
        end else begin
          settle_cnt <= settle_cnt + CNT_W'(1);
        end
        SHOW: if (step) begin
          valid <= 1'b0;
          if (chain) begin
            alu_a <= result_q;
            state <= ENTER_B;
          end else begin
            state <= ENTER_A;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

  assign state_q = state;

endmodule
